// File: rtl/random_seq_checker.sv
// random_seq_checker
//   Monitors the 4-bit random sequence counter output. The legal cycle is
//   0000->1101->1011->1001->0110->1100->0011->1111->0000. The checker
//   acquires lock, flags illegal codes and out-of-order steps, and counts
//   completed laps and errors. Samples are taken only when en is high.
//   All outputs are registered. clear is a synchronous, active-high reset.
//
//   Optional feature macro: RANDOM_SEQ_CHK_STICKY_EN
//     defined   : err_sticky sets on any error. It clears on clear, or on
//                 sticky_clr when no error occurs in the same cycle.
//     undefined : err_sticky is tied low and sticky_clr is ignored.
//
//   state  | meaning
//   IDLE   | no reference sample yet; waiting for any legal code
//   ACQ    | reference held, counting consecutive correct steps toward lock
//   LOCKED | sequence confirmed; every step is checked and laps are counted
module random_seq_checker #(
    parameter int LOCK_COUNT = 2,
    parameter int ERR_WIDTH  = 8,
    parameter int LAP_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 en,
    input  logic [3:0]           seq_in,
    input  logic                 sticky_clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [LAP_WIDTH-1:0] lap_count,
    output logic [3:0]           expected,
    output logic                 err_sticky
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_nxt;
    logic [3:0] prev, prev_nxt;
    logic [3:0] good_cnt, good_nxt;
    logic       err_raise;
    logic       lap_inc;

    function automatic logic [3:0] succ(input logic [3:0] v);
        case (v)
            4'b0000: succ = 4'b1101;
            4'b1101: succ = 4'b1011;
            4'b1011: succ = 4'b1001;
            4'b1001: succ = 4'b0110;
            4'b0110: succ = 4'b1100;
            4'b1100: succ = 4'b0011;
            4'b0011: succ = 4'b1111;
            default: succ = 4'b0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] v);
        case (v)
            4'b0000, 4'b1101, 4'b1011, 4'b1001,
            4'b0110, 4'b1100, 4'b0011, 4'b1111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // Next-state, reference and event decode; only a qualified sample moves anything.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        good_nxt  = good_cnt;
        err_raise = 1'b0;
        lap_inc   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (is_legal(seq_in)) begin
                        state_nxt = ACQ;
                        prev_nxt  = seq_in;
                        good_nxt  = 4'd0;
                    end else begin
                        err_raise = 1'b1;
                    end
                end
                ACQ: begin
                    if (!is_legal(seq_in)) begin
                        state_nxt = IDLE;
                        prev_nxt  = 4'b0000;
                        good_nxt  = 4'd0;
                        err_raise = 1'b1;
                    end else if (seq_in == succ(prev)) begin
                        prev_nxt = seq_in;
                        if (good_cnt + 4'd1 == LOCK_N) begin
                            state_nxt = LOCKED;
                            good_nxt  = 4'd0;
                        end else begin
                            good_nxt = good_cnt + 4'd1;
                        end
                    end else begin
                        // legal but out of order while acquiring: quiet resync
                        prev_nxt = seq_in;
                        good_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!is_legal(seq_in)) begin
                        state_nxt = IDLE;
                        prev_nxt  = 4'b0000;
                        good_nxt  = 4'd0;
                        err_raise = 1'b1;
                    end else if (seq_in == succ(prev)) begin
                        prev_nxt = seq_in;
                        lap_inc  = (prev == 4'b1111);
                    end else begin
                        state_nxt = ACQ;
                        prev_nxt  = seq_in;
                        good_nxt  = 4'd0;
                        err_raise = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    prev_nxt  = 4'b0000;
                    good_nxt  = 4'd0;
                end
            endcase
        end
    end

    // State, reference and registered outputs, with saturating counters.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            prev      <= 4'b0000;
            good_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            lap_count <= '0;
            expected  <= 4'b0000;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            good_cnt  <= good_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_raise;
            expected  <= (state_nxt == IDLE) ? 4'b0000 : succ(prev_nxt);
            if (err_raise && (err_count != {ERR_WIDTH{1'b1}}))
                err_count <= err_count + ERR_WIDTH'(1);
            if (lap_inc && (lap_count != {LAP_WIDTH{1'b1}}))
                lap_count <= lap_count + LAP_WIDTH'(1);
        end
    end

`ifdef RANDOM_SEQ_CHK_STICKY_EN
    // Sticky error flag; a new error takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (clear)
            err_sticky <= 1'b0;
        else if (err_raise)
            err_sticky <= 1'b1;
        else if (sticky_clr)
            err_sticky <= 1'b0;
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign err_sticky        = 1'b0;
`endif

endmodule
